// File: rtl/cad_input_loader.sv
// Front-end receiver for the CAD core: turns the serial image/kernel stream into
// SRAM byte writes and folds each two-beat command into a single-cycle pulse.
module cad_input_loader #(
  parameter int unsigned IMG_AW = 14,
  parameter int unsigned KER_AW = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        matrix,
  input  logic [1:0]        matrix_size,
  input  logic              in_valid2,
  input  logic              mode,
  input  logic [3:0]        matrix_idx,
  output logic              img_we,
  output logic [IMG_AW-1:0] img_addr,
  output logic [7:0]        img_wdata,
  output logic              ker_we,
  output logic [KER_AW-1:0] ker_addr,
  output logic [7:0]        ker_wdata,
  output logic [1:0]        size_o,
  output logic              load_done,
  output logic              cmd_valid,
  output logic              cmd_mode,
  output logic [3:0]        cmd_img_idx,
  output logic [3:0]        cmd_ker_idx
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StLoadImg = 3'd1;
  localparam logic [2:0] StLoadKer = 3'd2;
  localparam logic [2:0] StWaitCmd = 3'd3;
  localparam logic [2:0] StCmd2    = 3'd4;

  // 16 kernels x 25 elements
  localparam logic [KER_AW-1:0] KerLast = KER_AW'(399);

  logic [2:0]        state_q, state_d;
  logic [1:0]        size_q, size_d;
  logic [9:0]        pix_q, pix_d;
  logic [3:0]        img_no_q, img_no_d;
  logic [KER_AW-1:0] ker_cnt_q, ker_cnt_d;
  logic              img_we_q, img_we_d;
  logic [IMG_AW-1:0] img_addr_q, img_addr_d;
  logic [7:0]        img_wdata_q, img_wdata_d;
  logic              ker_we_q, ker_we_d;
  logic [KER_AW-1:0] ker_addr_q, ker_addr_d;
  logic [7:0]        ker_wdata_q, ker_wdata_d;
  logic              load_done_q, load_done_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              cmd_mode_q, cmd_mode_d;
  logic [3:0]        cmd_img_q, cmd_img_d;
  logic [3:0]        cmd_ker_q, cmd_ker_d;
  logic [9:0]        last_pix;

  // Last pixel offset of one image (N*N-1) for the latched size.
  always_comb begin
    last_pix = 10'd63;
    case (size_q)
      2'd1:    last_pix = 10'd255;
      2'd2:    last_pix = 10'd1023;
      default: last_pix = 10'd63;
    endcase
  end

  // Next-state, address counters and registered write/command outputs.
  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    pix_d       = pix_q;
    img_no_d    = img_no_q;
    ker_cnt_d   = ker_cnt_q;
    img_we_d    = 1'b0;
    img_addr_d  = img_addr_q;
    img_wdata_d = img_wdata_q;
    ker_we_d    = 1'b0;
    ker_addr_d  = ker_addr_q;
    ker_wdata_d = ker_wdata_q;
    load_done_d = load_done_q;
    cmd_valid_d = 1'b0;
    cmd_mode_d  = cmd_mode_q;
    cmd_img_d   = cmd_img_q;
    cmd_ker_d   = cmd_ker_q;

    case (state_q)
      StIdle, StWaitCmd, StCmd2: begin
        if (in_valid) begin
          // A new stream always wins over a pending command.
          size_d      = (matrix_size == 2'd3) ? 2'd0 : matrix_size;
          img_we_d    = 1'b1;
          img_addr_d  = '0;
          img_wdata_d = matrix;
          pix_d       = 10'd1;
          img_no_d    = 4'd0;
          load_done_d = 1'b0;
          state_d     = StLoadImg;
        end else if (state_q == StWaitCmd) begin
          if (in_valid2) begin
            cmd_mode_d = mode;
            cmd_img_d  = matrix_idx;
            state_d    = StCmd2;
          end
        end else if (state_q == StCmd2) begin
          // A missing second beat aborts the command silently.
          if (in_valid2) begin
            cmd_ker_d   = matrix_idx;
            cmd_valid_d = 1'b1;
          end
          state_d = StWaitCmd;
        end
      end
      StLoadImg: begin
        if (in_valid) begin
          img_we_d    = 1'b1;
          img_addr_d  = IMG_AW'({img_no_q, pix_q});
          img_wdata_d = matrix;
          if (pix_q == last_pix) begin
            pix_d = 10'd0;
            if (img_no_q == 4'd15) begin
              ker_cnt_d = '0;
              state_d   = StLoadKer;
            end else begin
              img_no_d = img_no_q + 4'd1;
            end
          end else begin
            pix_d = pix_q + 10'd1;
          end
        end
      end
      StLoadKer: begin
        if (in_valid) begin
          ker_we_d    = 1'b1;
          ker_addr_d  = ker_cnt_q;
          ker_wdata_d = matrix;
          if (ker_cnt_q == KerLast) begin
            load_done_d = 1'b1;
            state_d     = StWaitCmd;
          end else begin
            ker_cnt_d = ker_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      size_q      <= '0;
      pix_q       <= '0;
      img_no_q    <= '0;
      ker_cnt_q   <= '0;
      img_we_q    <= 1'b0;
      img_addr_q  <= '0;
      img_wdata_q <= '0;
      ker_we_q    <= 1'b0;
      ker_addr_q  <= '0;
      ker_wdata_q <= '0;
      load_done_q <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_mode_q  <= 1'b0;
      cmd_img_q   <= '0;
      cmd_ker_q   <= '0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      pix_q       <= pix_d;
      img_no_q    <= img_no_d;
      ker_cnt_q   <= ker_cnt_d;
      img_we_q    <= img_we_d;
      img_addr_q  <= img_addr_d;
      img_wdata_q <= img_wdata_d;
      ker_we_q    <= ker_we_d;
      ker_addr_q  <= ker_addr_d;
      ker_wdata_q <= ker_wdata_d;
      load_done_q <= load_done_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_mode_q  <= cmd_mode_d;
      cmd_img_q   <= cmd_img_d;
      cmd_ker_q   <= cmd_ker_d;
    end
  end

  assign img_we      = img_we_q;
  assign img_addr    = img_addr_q;
  assign img_wdata   = img_wdata_q;
  assign ker_we      = ker_we_q;
  assign ker_addr    = ker_addr_q;
  assign ker_wdata   = ker_wdata_q;
  assign size_o      = size_q;
  assign load_done   = load_done_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_mode    = cmd_mode_q;
  assign cmd_img_idx = cmd_img_q;
  assign cmd_ker_idx = cmd_ker_q;

endmodule

// File: tb/tb_cad_input_loader.sv
// Directed bench for cad_input_loader: reset, image/kernel loads of all three
// sizes (one with stalls), command decoding and protocol violations.
module tb_cad_input_loader;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  matrix;
  logic [1:0]  matrix_size;
  logic        in_valid2;
  logic        mode;
  logic [3:0]  matrix_idx;
  logic        img_we;
  logic [13:0] img_addr;
  logic [7:0]  img_wdata;
  logic        ker_we;
  logic [8:0]  ker_addr;
  logic [7:0]  ker_wdata;
  logic [1:0]  size_o;
  logic        load_done;
  logic        cmd_valid;
  logic        cmd_mode;
  logic [3:0]  cmd_img_idx;
  logic [3:0]  cmd_ker_idx;

  int checks = 0;
  int errors = 0;

  cad_input_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .matrix      (matrix),
    .matrix_size (matrix_size),
    .in_valid2   (in_valid2),
    .mode        (mode),
    .matrix_idx  (matrix_idx),
    .img_we      (img_we),
    .img_addr    (img_addr),
    .img_wdata   (img_wdata),
    .ker_we      (ker_we),
    .ker_addr    (ker_addr),
    .ker_wdata   (ker_wdata),
    .size_o      (size_o),
    .load_done   (load_done),
    .cmd_valid   (cmd_valid),
    .cmd_mode    (cmd_mode),
    .cmd_img_idx (cmd_img_idx),
    .cmd_ker_idx (cmd_ker_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock; outputs then reflect the beat just sampled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [61:0] all_out();
    return {img_we, img_addr, img_wdata, ker_we, ker_addr, ker_wdata, size_o, load_done,
            cmd_valid, cmd_mode, cmd_img_idx, cmd_ker_idx};
  endfunction

  // Streams one full load; tallies every per-beat deviation into bad.
  task automatic do_load(input int n, input logic [1:0] sz, input bit gaps,
                         output int img_n, output int ker_n, output int bad,
                         output logic [13:0] a64, output logic [13:0] last_a,
                         output logic ld_first, output logic ld_pre, output logic ld_end);
    int pp;
    int total;
    int g;
    int k;
    logic [13:0] exp_a;
    logic [8:0]  exp_k;
    pp = n * n;
    total = 16 * pp + 400;
    img_n = 0; ker_n = 0; bad = 0; a64 = '0; last_a = '0;
    ld_first = 1'bx; ld_pre = 1'bx; ld_end = 1'bx;
    for (int i = 0; i < total; i++) begin
      if (gaps && i > 0 && $urandom_range(0, 3) == 0) begin
        g = $urandom_range(1, 3);
        for (int j = 0; j < g; j++) begin
          in_valid   = 1'b0;
          in_valid2  = 1'($urandom_range(0, 1));
          mode       = 1'($urandom_range(0, 1));
          matrix_idx = 4'($urandom);
          matrix     = 8'($urandom);
          step();
          if (img_we !== 1'b0 || ker_we !== 1'b0 || cmd_valid !== 1'b0) bad++;
        end
        in_valid2 = 1'b0;
      end
      in_valid    = 1'b1;
      matrix      = i[7:0];
      matrix_size = (i == 0) ? sz : 2'd3;
      step();
      if (i < 16 * pp) begin
        exp_a = {4'(i / pp), 10'(i % pp)};
        if (img_we !== 1'b1 || ker_we !== 1'b0 || img_addr !== exp_a || img_wdata !== i[7:0])
          bad++;
      end else begin
        k = i - 16 * pp;
        exp_k = 9'(k);
        if (ker_we !== 1'b1 || img_we !== 1'b0 || ker_addr !== exp_k || ker_wdata !== i[7:0])
          bad++;
      end
      if (img_we === 1'b1) img_n++;
      if (ker_we === 1'b1) ker_n++;
      if (cmd_valid !== 1'b0) bad++;
      if (i > 0 && i < total - 1 && load_done !== 1'b0) bad++;
      if (i == 0) ld_first = load_done;
      if (i == 64) a64 = img_addr;
      if (i == 16 * pp - 1) last_a = img_addr;
      if (i == total - 2) ld_pre = load_done;
      if (i == total - 1) ld_end = load_done;
    end
    in_valid = 1'b0;
    matrix_size = 2'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid    = 1'($urandom_range(0, 1));
      matrix      = 8'($urandom);
      matrix_size = 2'($urandom);
      step();
      checks++;
      if (all_out() !== '0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got %h, expected 0", i, all_out());
      end
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    step();
    checks++;
    if ({img_we, ker_we, load_done, cmd_valid} !== 4'b0) begin
      errors++;
      $display("FAIL reset_release: got %b, expected 0000", {img_we, ker_we, load_done, cmd_valid});
    end
  endtask

  task automatic test_load_8x8();
    int img_n, ker_n, bad;
    logic [13:0] a64, last_a;
    logic ld_first, ld_pre, ld_end;
    do_load(8, 2'd0, 1'b0, img_n, ker_n, bad, a64, last_a, ld_first, ld_pre, ld_end);
    checks++; if (img_n !== 1024) begin errors++; $display("FAIL l8_img_count: got %0d, expected 1024", img_n); end
    checks++; if (ker_n !== 400) begin errors++; $display("FAIL l8_ker_count: got %0d, expected 400", ker_n); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL l8_beats: got %0d bad beats, expected 0", bad); end
    checks++; if (a64 !== 14'h0400) begin errors++; $display("FAIL l8_addr64: got %h, expected 0400", a64); end
    checks++; if (last_a !== 14'h3C3F) begin errors++; $display("FAIL l8_last_img: got %h, expected 3c3f", last_a); end
    checks++; if (ld_pre !== 1'b0 || ld_end !== 1'b1) begin errors++; $display("FAIL l8_load_done: got %b%b, expected 01", ld_pre, ld_end); end
    checks++; if (size_o !== 2'd0) begin errors++; $display("FAIL l8_size: got %0d, expected 0", size_o); end
    step();
    checks++;
    if (load_done !== 1'b1 || img_we !== 1'b0 || ker_we !== 1'b0) begin
      errors++;
      $display("FAIL l8_idle_after: got ld=%b iwe=%b kwe=%b, expected 1 0 0", load_done, img_we, ker_we);
    end
  endtask

  task automatic test_command();
    in_valid2 = 1'b1; mode = 1'b1; matrix_idx = 4'd5;
    step();
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL cmd_early: got %b, expected 0", cmd_valid); end
    mode = 1'b0; matrix_idx = 4'd12;
    step();
    in_valid2 = 1'b0;
    checks++;
    if ({cmd_valid, cmd_mode, cmd_img_idx, cmd_ker_idx} !== {1'b1, 1'b1, 4'd5, 4'd12}) begin
      errors++;
      $display("FAIL cmd_pulse: got v=%b m=%b i=%0d k=%0d, expected 1 1 5 12",
               cmd_valid, cmd_mode, cmd_img_idx, cmd_ker_idx);
    end
    step();
    checks++;
    if ({cmd_valid, cmd_mode, cmd_img_idx, cmd_ker_idx} !== {1'b0, 1'b1, 4'd5, 4'd12}) begin
      errors++;
      $display("FAIL cmd_hold: got v=%b m=%b i=%0d k=%0d, expected 0 1 5 12",
               cmd_valid, cmd_mode, cmd_img_idx, cmd_ker_idx);
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int bad = 0;
    for (int k = 0; k < 16; k++) begin
      in_valid2 = 1'b1; mode = k[0]; matrix_idx = 4'(k);
      step();
      if (cmd_valid === 1'b1) pulses++;
      mode = ~k[0]; matrix_idx = 4'(15 - k);
      step();
      if (cmd_valid === 1'b1) pulses++;
      if ({cmd_valid, cmd_mode, cmd_img_idx, cmd_ker_idx} !== {1'b1, k[0], 4'(k), 4'(15 - k)})
        bad++;
    end
    in_valid2 = 1'b0;
    step();
    if (cmd_valid === 1'b1) pulses++;
    checks++; if (pulses !== 16) begin errors++; $display("FAIL b2b_pulses: got %0d, expected 16", pulses); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_fields: got %0d bad commands, expected 0", bad); end
  endtask

  task automatic test_single_cycle();
    in_valid2 = 1'b1; mode = 1'b0; matrix_idx = 4'd3;
    step();
    in_valid2 = 1'b0;
    step();
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL single_abort: got %b, expected 0", cmd_valid); end
    step();
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL single_after: got %b, expected 0", cmd_valid); end
    in_valid2 = 1'b1; mode = 1'b1; matrix_idx = 4'd7;
    step();
    matrix_idx = 4'd9;
    step();
    in_valid2 = 1'b0;
    checks++;
    if ({cmd_valid, cmd_mode, cmd_img_idx, cmd_ker_idx} !== {1'b1, 1'b1, 4'd7, 4'd9}) begin
      errors++;
      $display("FAIL single_recover: got v=%b m=%b i=%0d k=%0d, expected 1 1 7 9",
               cmd_valid, cmd_mode, cmd_img_idx, cmd_ker_idx);
    end
  endtask

  task automatic test_reload_16x16();
    int img_n, ker_n, bad;
    logic [13:0] a64, last_a;
    logic ld_first, ld_pre, ld_end;
    step();
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL rl_before: got %b, expected 1", load_done); end
    do_load(16, 2'd1, 1'b0, img_n, ker_n, bad, a64, last_a, ld_first, ld_pre, ld_end);
    checks++; if (ld_first !== 1'b0) begin errors++; $display("FAIL rl_drop: got %b, expected 0", ld_first); end
    checks++; if (size_o !== 2'd1) begin errors++; $display("FAIL rl_size: got %0d, expected 1", size_o); end
    checks++; if (img_n !== 4096) begin errors++; $display("FAIL rl_img_count: got %0d, expected 4096", img_n); end
    checks++; if (ker_n !== 400) begin errors++; $display("FAIL rl_ker_count: got %0d, expected 400", ker_n); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rl_beats: got %0d bad beats, expected 0", bad); end
    checks++; if (last_a !== 14'h3CFF) begin errors++; $display("FAIL rl_last_img: got %h, expected 3cff", last_a); end
    checks++; if (ld_end !== 1'b1) begin errors++; $display("FAIL rl_done: got %b, expected 1", ld_end); end
    checks++;
    if ({cmd_mode, cmd_img_idx, cmd_ker_idx} !== {1'b1, 4'd7, 4'd9}) begin
      errors++;
      $display("FAIL rl_cmd_hold: got m=%b i=%0d k=%0d, expected 1 7 9", cmd_mode, cmd_img_idx, cmd_ker_idx);
    end
  endtask

  // Stalls carry random in_valid2 noise, which must be ignored while loading.
  task automatic test_load_32x32_stalls();
    int img_n, ker_n, bad;
    logic [13:0] a64, last_a;
    logic ld_first, ld_pre, ld_end;
    do_load(32, 2'd2, 1'b1, img_n, ker_n, bad, a64, last_a, ld_first, ld_pre, ld_end);
    checks++; if (img_n !== 16384) begin errors++; $display("FAIL l32_img_count: got %0d, expected 16384", img_n); end
    checks++; if (ker_n !== 400) begin errors++; $display("FAIL l32_ker_count: got %0d, expected 400", ker_n); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL l32_beats: got %0d bad beats, expected 0", bad); end
    checks++; if (a64 !== 14'h0040) begin errors++; $display("FAIL l32_addr64: got %h, expected 0040", a64); end
    checks++; if (last_a !== 14'h3FFF) begin errors++; $display("FAIL l32_last_img: got %h, expected 3fff", last_a); end
    checks++; if (size_o !== 2'd2) begin errors++; $display("FAIL l32_size: got %0d, expected 2", size_o); end
    checks++; if (ld_pre !== 1'b0 || ld_end !== 1'b1) begin errors++; $display("FAIL l32_load_done: got %b%b, expected 01", ld_pre, ld_end); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 71; i++) begin
      in_valid = 1'b1; matrix = 8'(i); matrix_size = (i == 0) ? 2'd3 : 2'd2;
      step();
      if (i == 0) begin
        checks++; if (size_o !== 2'd0) begin errors++; $display("FAIL mr_size3: got %0d, expected 0", size_o); end
      end
    end
    checks++; if (img_addr !== 14'h0406) begin errors++; $display("FAIL mr_addr70: got %h, expected 0406", img_addr); end
    rst_n = 1'b0;
    step();
    checks++; if (all_out() !== '0) begin errors++; $display("FAIL mr_reset: got %h, expected 0", all_out()); end
    rst_n = 1'b1; in_valid = 1'b0;
    step();
    step();
    checks++;
    if ({img_we, ker_we, load_done} !== 3'b0) begin
      errors++;
      $display("FAIL mr_after: got %b, expected 000", {img_we, ker_we, load_done});
    end
    in_valid = 1'b1; matrix = 8'hAB; matrix_size = 2'd0;
    step();
    in_valid = 1'b0;
    checks++;
    if ({img_we, img_addr, img_wdata} !== {1'b1, 14'h0000, 8'hAB}) begin
      errors++;
      $display("FAIL mr_restart: got we=%b a=%h d=%h, expected 1 0000 ab", img_we, img_addr, img_wdata);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; matrix = '0; matrix_size = '0;
    in_valid2 = 1'b0; mode = 1'b0; matrix_idx = '0;
    test_reset();
    test_load_8x8();
    test_command();
    test_back_to_back();
    test_single_cycle();
    test_reload_16x16();
    test_load_32x32_stalls();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cad_input_loader.md
Name: cad_input_loader

Overview:
- Front-end receiver for the CAD core.
- Samples the serial matrix stream on in_valid (16 images of size NxN, then 16 kernels of 5x5) and turns it into byte writes for the image and kernel SRAMs.
- Captures each two-cycle in_valid2 command (mode, image index, kernel index) and presents it as a one-cycle command pulse to the compute/output engine.

Parameters:
- IMG_AW, 14, image SRAM address width (16 slots x 1024 bytes)
- KER_AW, 9, kernel SRAM address width (400 bytes used)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  matrix stream valid
- matrix  in  8  signed image/kernel byte
- matrix_size  in  2  0:8x8, 1:16x16, 2:32x32; valid only on first in_valid cycle; 3 reserved
- in_valid2  in  1  command valid, exactly 2 consecutive cycles
- mode  in  1  valid on first in_valid2 cycle only
- matrix_idx  in  4  cycle 1: image index, cycle 2: kernel index
- img_we  out  1  image SRAM write strobe
- img_addr  out  IMG_AW  {image_no[3:0], pixel_offset[9:0]}
- img_wdata  out  8  byte to write
- ker_we  out  1  kernel SRAM write strobe
- ker_addr  out  KER_AW  kernel_no*25 + element
- ker_wdata  out  8  byte to write
- size_o  out  2  latched matrix_size, held until next load
- load_done  out  1  level; high from load completion until next load starts
- cmd_valid  out  1  one-cycle command pulse
- cmd_mode  out  1  captured mode
- cmd_img_idx  out  4  captured image index
- cmd_ker_idx  out  4  captured kernel index

Behaviour:
- Reset (rst_n low at a rising edge): all outputs 0, FSM to IDLE, counters 0. Applies mid-load: partial writes are abandoned, load_done stays 0.
- FSM states: IDLE, LOAD_IMG, LOAD_KER, WAIT_CMD, CMD2.
- IDLE: the first in_valid=1 cycle latches matrix_size into size_o and N = 8/16/32, writes byte 0 (image 0, offset 0), and moves to LOAD_IMG with pix=1. matrix_size=3 is treated as 0.
- LOAD_IMG: each in_valid=1 cycle writes matrix to {img_no, pix}, then pix++. When pix reaches N*N-1 on a write, pix wraps to 0 and img_no++. After the write of image 15, last pixel, go to LOAD_KER with ker_addr counter 0.
- Image totals: 1024 / 4096 / 16384 bytes for N = 8 / 16 / 32.
- LOAD_KER: each in_valid=1 cycle writes ker_addr (0..399), then increments. After the write at address 399, set load_done=1 and go to WAIT_CMD.
- Stalls: in_valid=0 inside LOAD_IMG or LOAD_KER holds all counters and issues no write. The stream resumes on the next in_valid=1.
- Write timing: img_we/ker_we, address and data are registered, appearing one cycle after the sampled in_valid beat. At most one strobe is high per cycle. Strobes are 0 in all other cycles.
- in_valid2 is ignored in IDLE, LOAD_IMG and LOAD_KER.
- WAIT_CMD, in_valid2=1: capture mode and matrix_idx into cmd_mode/cmd_img_idx, go to CMD2.
- WAIT_CMD, in_valid=1: start a new load (same as IDLE). load_done drops to 0 the same cycle the first write is issued; cmd_* fields hold their values.
- CMD2: capture matrix_idx into cmd_ker_idx. cmd_valid=1 in the cycle after the second in_valid2 beat, for exactly one cycle, then back to WAIT_CMD.
- CMD2 with in_valid2=0 (protocol violation): abort, no cmd_valid, return to WAIT_CMD.
- cmd_* fields hold their values until the next capture. Any number of commands (16 per pattern) may follow one load.
- in_valid and in_valid2 never overlap. If they do, in_valid has priority.

Test Plan:
- Reset: hold rst_n=0 for 10 cycles during random in_valid -> every output 0 at each edge; after release the FSM is in IDLE and load_done=0.
- 8x8 load: matrix_size=0, bytes = index mod 256 for 1024+400 beats -> img_we count 1024; beat 64 goes to img_addr 0x0400 (image 1, offset 0); last image write at addr 0x3C3F; ker_addr 0..399 with data matching; load_done=1 one cycle after write 399.
- 32x32 with stalls: random 1-3 cycle in_valid gaps -> exactly 16384 image and 400 kernel writes; no strobe during gaps; last image addr 0x3FFF.
- Command: mode=1, idx 5 then 12 -> cmd_valid high exactly one cycle, 1 cycle after the second beat, with cmd_mode=1, img=5, ker=12; 16 back-to-back commands produce 16 pulses.
- Reload: new in_valid with matrix_size=1 while in WAIT_CMD -> load_done falls, size_o=1, 4096 image writes, load_done rises again.
- Violations: in_valid2 during LOAD_KER -> ignored, no cmd_valid. Single-cycle in_valid2 -> no cmd_valid, the next valid pair is decoded correctly.
